// File: rtl/parallel_to_serial_framer_pkg.sv
// Shared definitions for the serial frame link (framer and receiver wrapper).
// PARITY_EN selects the optional trailing parity bit in the framer.
package parallel_to_serial_framer_pkg;

    localparam int DEF_WIDTH            = 8;
    localparam int DEF_FRAME_SIZE_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_DONE   = 3'd3,
        ST_PARITY = 3'd4
    } state_e;

endpackage

// File: rtl/parallel_to_serial_framer_if.sv
// Parallel word valid/ready handshake between the packet builder (master) and
// the framer (slave).
interface parallel_to_serial_framer_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] parallel;
    logic             parallel_valid;
    logic             parallel_ready;

    modport master (output parallel, output parallel_valid, input parallel_ready);
    modport slave  (input parallel, input parallel_valid, output parallel_ready);
endinterface

// File: rtl/parallel_to_serial_framer_frame_bit_counter.sv
// Frame bit up-counter with terminal compare against the latched frame length.
module parallel_to_serial_framer_frame_bit_counter #(
    parameter int FRAME_SIZE_WIDTH = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_clr,
    input  logic                        i_en,
    input  logic [FRAME_SIZE_WIDTH-1:0] i_fsize,
    output logic                        o_tc
);
    logic [FRAME_SIZE_WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // i_fsize is never zero while counting, so fsize-1 cannot underflow here
    assign o_tc = (r_cnt == (i_fsize - 1'b1));
endmodule

// File: rtl/parallel_to_serial_framer.sv
// Parallel-to-serial frame transmitter, MSB first, line tri-stated between frames.
// Define PARITY_EN to append an even-parity bit after the data bits.
//
// state  | meaning
// IDLE   | line released, waiting for an enabled start with nonzero length
// FETCH  | waiting for the first word of the frame
// SHIFT  | driving frame data bits, reloading at word boundaries
// PARITY | driving the even-parity bit (PARITY_EN builds only)
// DONE   | line released, complete pulse, back to IDLE
module parallel_to_serial_framer
    import parallel_to_serial_framer_pkg::*;
#(
    parameter int WIDTH            = DEF_WIDTH,
    parameter int FRAME_SIZE_WIDTH = DEF_FRAME_SIZE_WIDTH
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_enable,
    input  logic                          i_start,
    input  logic [FRAME_SIZE_WIDTH-1:0]   i_framesize,
    parallel_to_serial_framer_if.slave    p_if,
    output wire                           o_serial,
    output logic                          o_serial_oe,
    output logic                          o_busy,
    output logic                          o_complete,
    output logic                          o_underrun
);
    localparam int WCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e                      r_state;
    state_e                      w_state_nxt;
    logic [WIDTH-1:0]            r_shreg;
    logic [WCW-1:0]              r_word_cnt;
    logic [FRAME_SIZE_WIDTH-1:0] r_fsize;
    logic                        r_underrun;
    logic                        w_start_ok;
    logic                        w_word_last;
    logic                        w_tc;
    logic                        w_ready;
    logic                        w_load;
    logic                        w_cnt_clr;
    logic                        w_cnt_en;
    logic                        w_oe;
    logic                        w_bit;
    logic                        w_underrun_nxt;
`ifdef PARITY_EN
    logic                        r_parity;
`endif

    assign w_start_ok  = i_start & i_enable & (i_framesize != '0);
    assign w_word_last = (r_word_cnt == WCW'(WIDTH - 1));

    parallel_to_serial_framer_frame_bit_counter #(
        .FRAME_SIZE_WIDTH(FRAME_SIZE_WIDTH)
    ) u_frame_bit_counter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .i_fsize (r_fsize),
        .o_tc    (w_tc)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_ready        = 1'b0;
        w_load         = 1'b0;
        w_cnt_clr      = 1'b0;
        w_cnt_en       = 1'b0;
        w_oe           = 1'b0;
        w_bit          = 1'b0;
        w_underrun_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                w_ready = 1'b1;
                if (p_if.parallel_valid) begin
                    w_load      = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_oe     = 1'b1;
                w_bit    = r_shreg[WIDTH-1];
                w_cnt_en = 1'b1;
                // last bit wins over a word boundary, so no fetch on the final bit
                if (w_tc) begin
`ifdef PARITY_EN
                    w_state_nxt = ST_PARITY;
`else
                    w_state_nxt = ST_DONE;
`endif
                end else if (w_word_last) begin
                    w_ready = 1'b1;
                    if (p_if.parallel_valid) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt    = ST_IDLE;
                        w_underrun_nxt = 1'b1;
                    end
                end
            end
`ifdef PARITY_EN
            ST_PARITY: begin
                w_oe        = 1'b1;
                w_bit       = r_parity;
                w_state_nxt = ST_DONE;
            end
`endif
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_underrun <= w_underrun_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fsize    <= '0;
            r_shreg    <= '0;
            r_word_cnt <= '0;
        end else begin
            if (r_state == ST_IDLE && w_start_ok) r_fsize <= i_framesize;
            if (w_load) begin
                r_shreg <= p_if.parallel;
            end else if (r_state == ST_SHIFT) begin
                r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
            end
            if (w_cnt_clr) begin
                r_word_cnt <= '0;
            end else if (r_state == ST_SHIFT) begin
                r_word_cnt <= w_word_last ? '0 : r_word_cnt + 1'b1;
            end
        end
    end

`ifdef PARITY_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_parity <= 1'b0;
        end else if (w_cnt_clr) begin
            r_parity <= 1'b0;
        end else if (r_state == ST_SHIFT) begin
            r_parity <= r_parity ^ r_shreg[WIDTH-1];
        end
    end
`endif

    assign p_if.parallel_ready = w_ready;
    assign o_serial            = w_oe ? w_bit : 1'bz;
    assign o_serial_oe         = w_oe;
    assign o_busy              = (r_state != ST_IDLE);
    assign o_complete          = (r_state == ST_DONE);
    assign o_underrun          = r_underrun;
endmodule

// File: tb/tb_parallel_to_serial_framer.sv
// Self-checking bench for parallel_to_serial_framer against a bit-stream model.
// Honours PARITY_EN to expect the trailing parity bit.
module tb_parallel_to_serial_framer;
    localparam int W   = 8;
    localparam int FSW = 8;
`ifdef PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           enable;
    logic           start;
    logic [FSW-1:0] framesize;
    wire            serial;
    logic           serial_oe;
    logic           busy;
    logic           complete;
    logic           underrun;

    logic [W-1:0]   words [0:39];
    int             n_checks = 0;
    int             n_errors = 0;

    parallel_to_serial_framer_if #(.WIDTH(W)) par_if ();

    parallel_to_serial_framer #(.WIDTH(W), .FRAME_SIZE_WIDTH(FSW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_enable    (enable),
        .i_start     (start),
        .i_framesize (framesize),
        .p_if        (par_if),
        .o_serial    (serial),
        .o_serial_oe (serial_oe),
        .o_busy      (busy),
        .o_complete  (complete),
        .o_underrun  (underrun)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame bit idx is bit (W-1 - idx%W) of word idx/W; the bit after the data is even parity.
    function automatic logic model_bit(input int idx, input int f);
        logic p;
        p = 1'b0;
        if (idx / W > 39) return 1'bx;
        if (idx < f) return words[idx / W][W - 1 - (idx % W)];
        for (int k = 0; k < f; k++) p ^= words[k / W][W - 1 - (k % W)];
        return p;
    endfunction

    function automatic logic model_ready(input int idx, input int f);
        return (idx < f - 1) && ((idx % W) == W - 1);
    endfunction

    task automatic fill_words();
        for (int i = 0; i < 40; i++) words[i] = W'($urandom);
    endtask

    task automatic run_frame(input int f, input int navail, input int delay);
        int accepted, nbits, first, fin, nready, exp_bits, exp_rdy;
        bit got_cpl, got_und, exp_und;
        accepted = 0; nbits = 0; first = -1; fin = -1; nready = 0;
        got_cpl = 0; got_und = 0;
        exp_und  = (navail * W < f);
        exp_bits = exp_und ? navail * W : f + PAR;
        exp_rdy  = exp_und ? navail - 1 + 1 : (f - 1) / W;
        @(negedge clk);
        enable = 1'b1; start = 1'b1; framesize = FSW'(f);
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= delay + f + 12; cyc++) begin
            framesize = FSW'($urandom);
            enable    = 1'($urandom);
            par_if.parallel_valid = (cyc > delay) && (accepted < navail);
            par_if.parallel       = par_if.parallel_valid ? words[accepted] : W'($urandom);
            #1;
            if (cyc == 1) check_val("fetch", {busy, serial_oe, par_if.parallel_ready}, 3'b101);
            if (serial_oe) begin
                if (first < 0) first = cyc;
                check_val("bit", {serial, par_if.parallel_ready, busy},
                          {model_bit(nbits, f), model_ready(nbits, f), 1'b1});
                nbits++;
                if (par_if.parallel_ready) nready++;
            end
            if (par_if.parallel_valid && par_if.parallel_ready) accepted++;
            if (complete || underrun) begin
                got_cpl = complete;
                got_und = underrun;
                fin     = cyc;
                check_val("oe_end", serial_oe, 1'b0);
                break;
            end
            @(negedge clk);
        end
        check_val("end_kind", {got_cpl, got_und}, {!exp_und, exp_und});
        check_val("nbits", nbits, exp_bits);
        check_val("latency", first, delay + 2);
        check_val("tail", fin - first, exp_bits);
        check_val("nready", nready, exp_rdy);
        @(negedge clk);
        par_if.parallel_valid = 1'b0;
        enable = 1'b1;
        #1;
        check_val("idle", {busy, serial_oe, complete, underrun}, 4'b0000);
    endtask

    task automatic ignored_start(input int f, input logic en);
        @(negedge clk);
        start = 1'b1; enable = en; framesize = FSW'(f);
        par_if.parallel_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_val("ignored", {busy, serial_oe, complete, underrun, par_if.parallel_ready}, 5'b0);
            @(negedge clk);
        end
        par_if.parallel_valid = 1'b0;
        enable = 1'b1;
    endtask

    task automatic reset_mid_frame();
        fill_words();
        @(negedge clk);
        enable = 1'b1; start = 1'b1; framesize = FSW'(40);
        @(negedge clk);
        start = 1'b0;
        par_if.parallel_valid = 1'b1;
        par_if.parallel       = words[0];
        repeat (5) @(negedge clk);
        #1;
        check_val("pre_rst_oe", {busy, serial_oe}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_async", {busy, serial_oe, par_if.parallel_ready}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        par_if.parallel_valid = 1'b0;
        @(negedge clk);
        #1;
        check_val("post_rst", {busy, serial_oe, complete, underrun, par_if.parallel_ready}, 5'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f, need, navail;
        rst_n = 1'b0; enable = 1'b0; start = 1'b0; framesize = '0;
        par_if.parallel = '0; par_if.parallel_valid = 1'b0;
        #12;
        check_val("reset", {busy, serial_oe, complete, underrun, par_if.parallel_ready}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;

        words[0] = 8'hA5;
        run_frame(8, 1, 0);

        words[0] = 8'hF0; words[1] = 8'h0F; words[2] = 8'hC3;
        run_frame(20, 3, 0);

        fill_words();
        run_frame(16, 1, 0);
        run_frame(16, 2, 1);

        ignored_start(0, 1'b1);
        ignored_start(5, 1'b0);

        reset_mid_frame();
        words[0] = 8'h07;
        run_frame(8, 1, 2);

        for (int t = 0; t < 25; t++) begin
            fill_words();
            f    = $urandom_range(1, 60);
            need = (f + W - 1) / W;
            navail = ($urandom_range(0, 3) == 0) ? $urandom_range(1, need) : need + 1;
            run_frame(f, navail, $urandom_range(0, 3));
        end

        fill_words();
        run_frame(255, 32, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/parallel_to_serial_framer.md
Name: parallel_to_serial_framer

Overview:
Transmit end of the serial frame link. Accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first on a single serial line for exactly framesize bits. Drives the line only while a frame is in flight and releases it to high-Z otherwise, so the paired serial receiver's "line not Z" frame detection and bit counting work unchanged. Sits between the packet/command builder and the serial pad.

Parameters:
WIDTH, 8, bits per parallel word and shift-register width
FRAME_SIZE_WIDTH, 8, width of framesize and of the frame bit counter

Ports:
Clock  input  1  single clock; all state changes on posedge
Reset  input  1  asynchronous, active-low; 0 forces idle immediately
Enable  input  1  start qualifier; start ignored while 0
start  input  1  one-cycle request to begin a frame (sampled in IDLE)
framesize  input  FRAME_SIZE_WIDTH  frame length in bits, latched on accepted start
parallel  input  WIDTH  word to transmit
parallel_valid  input  1  parallel holds a valid word
parallel_ready  output  1  block accepts parallel this cycle (transfer = valid & ready)
serial  output  1  serial data; 1'bz when not transmitting
serial_oe  output  1  1 while serial is driven
busy  output  1  1 in any state but IDLE
complete  output  1  one-cycle pulse after the last frame bit
underrun  output  1  one-cycle pulse when a frame is aborted for lack of data

Behaviour:
- Reset low: state IDLE; shift reg, bit_cnt, word_cnt, fsize_q = 0; serial = z, serial_oe/busy/complete/underrun/parallel_ready = 0. Takes effect asynchronously, including mid-frame (line released the same instant).
- States: IDLE, FETCH, SHIFT, DONE.
- IDLE: start & Enable & framesize != 0 -> latch fsize_q = framesize, go FETCH. framesize == 0 -> start ignored, no pulses.
- FETCH: parallel_ready = 1. On transfer: shreg <= parallel, bit_cnt <= 0, word_cnt <= 0, go SHIFT. Waits indefinitely; serial stays z.
- SHIFT: serial_oe = 1, serial = shreg[WIDTH-1]. Each cycle: shreg shifts left by 1, bit_cnt++, word_cnt++ (wraps at WIDTH-1 -> 0).
  - bit_cnt == fsize_q-1 -> go DONE (last bit; remaining shreg bits discarded, partial words allowed).
  - else word_cnt == WIDTH-1 -> parallel_ready = 1 this cycle; transfer -> shreg <= parallel (seamless, no gap bit); no transfer -> go IDLE, underrun pulses next cycle, line released (receiver sees Z and resets).
  - parallel_ready never asserted on the frame's final bit.
- DONE: serial = z, serial_oe = 0, complete = 1 for one cycle, -> IDLE. start in DONE ignored.
- Latency: start accepted cycle n -> FETCH n+1; transfer at n+1 -> first bit driven n+2; frame of F bits occupies cycles n+2..n+F+1; complete at n+F+2.
- Back-to-back: earliest new start sampled in the IDLE cycle after DONE; line is z for at least one cycle between frames.
- framesize changes mid-frame have no effect (fsize_q used). Enable deassert mid-frame has no effect.
- bit_cnt is FRAME_SIZE_WIDTH bits; max frame 2^FRAME_SIZE_WIDTH-1 bits, no wrap.

Optional Feature:
Macro PARITY_EN. Defined: after the fsize_q data bits, state PARITY drives one extra bit = even parity (XOR of all data bits sent), serial_oe = 1, then DONE; complete shifts one cycle later. Not defined: no PARITY state, frame is exactly fsize_q bits.

Decomposition:
- Shared package: state encoding constants (IDLE/FETCH/SHIFT/DONE/PARITY), default WIDTH and FRAME_SIZE_WIDTH constants shared with the receiver wrapper.
- One sub-module: frame_bit_counter (up-counter with async active-low reset, sync clear, enable, terminal-compare against fsize_q) instantiated for bit_cnt; word_cnt stays inline.

Test Plan:
- Reset low mid-SHIFT -> serial z and busy 0 within the same cycle; after release, idle with all pulses 0.
- WIDTH=8, framesize=8, word 0xA5 valid with start -> serial 1,0,1,0,0,1,0,1 on cycles n+2..n+9, complete at n+10, line z elsewhere.
- framesize=20, words 0xF0, 0x0F, 0xC3 all valid -> 20 contiguous bits 11110000_00001111_1100, parallel_ready pulsed on bits 7 and 15 only, no gaps.
- framesize=16, second word withheld -> 8 bits sent, underrun pulse, line z, no complete; next start works normally.
- framesize=0 with start, and start with Enable=0 -> no state change, serial stays z.
- PARITY_EN, framesize=8, word 0x07 -> 8 data bits then parity bit 1, complete one cycle later; loopback into the receiver wrapper yields parallel 0x07.
